cpu_control: RTL

Multi-cycle control unit for the orgasmall CPU core. It sequences each instruction through fetch, decode, execute and optional memory phases, and owns the program counter and the C/Z/N flag register. It drives the write enables and data-routing selects for the register file, ALU flags and data memory, and halts the core on an invalid opcode. It sits between the decoder (opcode/immediate) and the `registers`, `alu` and `memory` instances inside `cpu`.

---
 rtl/cpu_control.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_control.sv
// Multi-cycle sequencer for the orgasmall core: walks each instruction through
// FETCH/DECODE/EXEC/MEM, owns the PC and C/Z/N flags, and halts on a bad opcode.
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef OPCODE_BITS
`define OPCODE_BITS 5
`endif

package cpu_control_pkg;
    localparam int OP_ADD   = 0;
    localparam int OP_ADC   = 1;
    localparam int OP_SUB   = 2;
    localparam int OP_AND   = 3;
    localparam int OP_OR    = 4;
    localparam int OP_XOR   = 5;
    localparam int OP_INC   = 6;
    localparam int OP_DEC   = 7;
    localparam int OP_SHR   = 8;
    localparam int OP_SHL   = 9;
    localparam int OP_CMP   = 10;
    localparam int OP_MOV   = 11;
    localparam int OP_SET   = 12;
    localparam int OP_STR   = 13;
    localparam int OP_RSTR  = 14;
    localparam int OP_LOAD  = 15;
    localparam int OP_RLOAD = 16;
    localparam int OP_JMP   = 17;
    localparam int OP_JC    = 18;
    localparam int OP_JZ    = 19;
    localparam int OP_JN    = 20;

    localparam logic [1:0] REG_SRC_ALU = 2'd0;
    localparam logic [1:0] REG_SRC_IMM = 2'd1;
    localparam logic [1:0] REG_SRC_MEM = 2'd2;
endpackage

module cpu_control
    import cpu_control_pkg::*;
#(
    parameter int ADDR_SIZE   = `ADDR_SIZE,
    parameter int OPCODE_BITS = `OPCODE_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [OPCODE_BITS-1:0] opcode,
    input  logic [ADDR_SIZE-1:0]   imm_addr,
    input  logic                   alu_c,
    input  logic                   alu_z,
    input  logic                   alu_n,
    output logic [ADDR_SIZE-1:0]   pc,
    output logic                   ir_load,
    output logic                   reg_we,
    output logic [1:0]             reg_src,
    output logic                   dmem_we,
    output logic                   dmem_addr_sel,
    output logic                   flag_c,
    output logic                   flag_z,
    output logic                   flag_n,
    output logic                   halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] pc_q, pc_d, pc_inc;
    logic                 flag_c_q, flag_c_d;
    logic                 flag_z_q, flag_z_d;
    logic                 flag_n_q, flag_n_d;
    logic [31:0]          op_v;
    logic                 op_valid;
    logic                 load_flags;

    assign op_v     = 32'(opcode);
    assign op_valid = (op_v <= OP_JN);
    assign pc_inc   = pc_q + ADDR_SIZE'(1);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        load_flags    = 1'b0;
        ir_load       = 1'b0;
        reg_we        = 1'b0;
        reg_src       = REG_SRC_ALU;
        dmem_we       = 1'b0;
        dmem_addr_sel = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (run) begin
                    // Gated by reset so the IR never loads while the core is held in reset.
                    ir_load = rst;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = op_valid ? S_EXEC : S_HALT;
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (op_v)
                    OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR,
                    OP_XOR, OP_INC, OP_DEC, OP_SHR, OP_SHL: begin
                        reg_we     = 1'b1;
                        load_flags = 1'b1;
                    end
                    OP_CMP:  load_flags = 1'b1;
                    OP_MOV:  reg_we = 1'b1;
                    OP_SET: begin
                        reg_we  = 1'b1;
                        reg_src = REG_SRC_IMM;
                    end
                    OP_STR:  dmem_we = 1'b1;
                    OP_RSTR: begin
                        dmem_we       = 1'b1;
                        dmem_addr_sel = 1'b1;
                    end
                    // Loads advance the PC only when they leave MEM.
                    OP_LOAD: begin
                        state_d = S_MEM;
                        pc_d    = pc_q;
                    end
                    OP_RLOAD: begin
                        dmem_addr_sel = 1'b1;
                        state_d       = S_MEM;
                        pc_d          = pc_q;
                    end
                    OP_JMP:  pc_d = imm_addr;
                    OP_JC:   if (flag_c_q) pc_d = imm_addr;
                    OP_JZ:   if (flag_z_q) pc_d = imm_addr;
                    OP_JN:   if (flag_n_q) pc_d = imm_addr;
                    default: ;
                endcase
            end
            S_MEM: begin
                reg_we        = 1'b1;
                reg_src       = REG_SRC_MEM;
                dmem_addr_sel = (op_v == OP_RLOAD);
                pc_d          = pc_inc;
                state_d       = S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase

        flag_c_d = load_flags ? alu_c : flag_c_q;
        flag_z_d = load_flags ? alu_z : flag_z_q;
        flag_n_d = load_flags ? alu_n : flag_n_q;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
        end
    end

    assign pc     = pc_q;
    assign flag_c = flag_c_q;
    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
    assign halted = (state_q == S_HALT);

endmodule
